dist_fifo32: RTL
================

Name: dist_fifo32

Overview:
- Single-clock, 32-deep synchronous FIFO built on 32x1 dual-port distributed RAM, one RAM bit-slice per data bit.
- The write side drives the RAM write port (address, data, write enable).
- The read side drives the dual-port read address and registers the asynchronous read data.
- Used as a shallow rate-decoupling buffer between datapath stages where a block RAM would be wasteful.

Parameters:
- WIDTH, 8, data width in bits (1..64); one 32x1 RAM slice per bit.
- AFULL_LVL, 28, almost_full asserts when count >= AFULL_LVL (1..31).

Ports:
- clk  in  1  single clock; RAM write clock and all registers.
- resetb  in  1  asynchronous active-low reset.
- wr_en  in  1  write request; data accepted on the clk rising edge when accepted (see Behaviour).
- din  in  WIDTH  write data.
- full  out  1  count == 32.
- almost_full  out  1  count >= AFULL_LVL.
- rd_en  in  1  read request.
- dout  out  WIDTH  registered read data.
- dout_valid  out  1  one-cycle pulse; dout holds a newly popped word.
- empty  out  1  count == 0.
- count  out  6  words stored, 0..32.
- overflow  out  1  sticky; set when a write is rejected.
- underflow  out  1  sticky; set when a read is rejected.
- clr_err  in  1  synchronous clear of overflow and underflow.

Behaviour:
- Storage: 32 x WIDTH dual-port distributed RAM.
  - Write address = wr_ptr[4:0], data = din, write enable = wr_acc.
  - Read address (DPRA) = rd_ptr[4:0]; RAM read is combinational.
- Pointers: wr_ptr and rd_ptr are 5 bits and wrap naturally 31->0. count is a 6-bit register; full/empty are derived from count.
- Acceptance:
  - rd_acc = rd_en & ~empty.
  - wr_acc = wr_en & (~full | rd_acc); a write into a full FIFO is accepted only when a read occurs in the same cycle.
  - Write while empty plus read: the read is rejected (empty), the write is accepted, count goes 0->1.
- Per rising edge:
  - wr_acc: RAM[wr_ptr] <= din; wr_ptr++.
  - rd_acc: dout <= RAM[rd_ptr] (pre-edge value); rd_ptr++; dout_valid <= 1. Otherwise dout_valid <= 0 and dout holds its value.
  - count: +1 on wr_acc only, -1 on rd_acc only, unchanged on both or neither.
- Read latency: dout/dout_valid are valid in the cycle after rd_en is sampled. A word written at edge N is readable with rd_en in cycle N+1, with data out after edge N+1.
- Full with simultaneous read and write: wr_ptr == rd_ptr. The read captures the old word because the RAM read is asynchronous and sampled before the write edge; the new word is stored in the freed slot.
- Errors:
  - overflow <= 1 when wr_en & ~wr_acc.
  - underflow <= 1 when rd_en & ~rd_acc.
  - clr_err clears both; if clr_err and a new error occur in the same cycle, set wins.
- Flags: almost_full, full, empty and count are all registered-derived, with no combinational path from wr_en/rd_en.
- Reset (resetb low, asynchronous, any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_full=0, dout=0, dout_valid=0, overflow=0, underflow=0.
  - RAM contents are not cleared; after reset the FIFO is logically empty and stale data is never presented.
  - Deassertion takes effect at the first clk edge with resetb high.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on consecutive cycles, then rd_en for 3 cycles -> dout 0x11,0x22,0x33 each one cycle after rd_en with dout_valid high; count 0,1,2,3,2,1,0; empty returns to 1.
- Write 32 words 0x00..0x1F -> full=1 and count=32 after the 32nd edge; almost_full rises when count reaches 28. A 33rd write -> rejected, overflow=1, count stays 32; drain -> 0x00..0x1F in order.
- Full, then simultaneous wr_en(din=0xAA)+rd_en -> dout=0x00, count stays 32. Drain -> 0x01..0x1F then 0xAA.
- Empty, then rd_en alone -> underflow=1, dout_valid=0, dout unchanged. Next, wr_en(0x5C)+rd_en same cycle -> count=1, no dout_valid. clr_err -> both error flags 0.
- Wrap: 100 cycles of a write/read every cycle after priming 5 words -> pointers wrap; output sequence is an exact in-order copy of the input; count constant at 5.
- Assert resetb low mid-burst with 10 words stored -> all outputs take reset values immediately (asynchronously). After release, a read is rejected (underflow=1); write 0x77 then read -> dout=0x77.

Source files
------------

// File: rtl/dist_fifo32_if.sv
// Handshake and status bundle for the 32-deep distributed-RAM FIFO.
// The master drives write/read requests; the slave is the FIFO itself.
interface dist_fifo32_if #(
   parameter int WIDTH = 8
);
   logic             wr_en;
   logic [WIDTH-1:0] din;
   logic             full;
   logic             almost_full;
   logic             rd_en;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             empty;
   logic [5:0]       count;
   logic             overflow;
   logic             underflow;
   logic             clr_err;

   modport master (
      output wr_en, din, rd_en, clr_err,
      input  full, almost_full, dout, dout_valid, empty, count, overflow, underflow
   );

   modport slave (
      input  wr_en, din, rd_en, clr_err,
      output full, almost_full, dout, dout_valid, empty, count, overflow, underflow
   );
endinterface

// File: rtl/dist_fifo32.sv
// Single-clock 32-deep FIFO on 32xWIDTH dual-port distributed RAM with an
// asynchronous read port and a registered output word.
module dist_fifo32 #(
   parameter int WIDTH     = 8,
   parameter int AFULL_LVL = 28
) (
   input logic           clk,
   input logic           resetb,
   dist_fifo32_if.slave  bus
);
   logic [WIDTH-1:0] mem_q [32];

   logic [4:0]       wr_ptr_q, wr_ptr_d;
   logic [4:0]       rd_ptr_q, rd_ptr_d;
   logic [5:0]       count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_valid_q, dout_valid_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;

   logic empty, full, rd_acc, wr_acc;

   // Flags come from the count register only, so no request-to-flag path exists.
   assign empty = (count_q == 6'd0);
   assign full  = (count_q == 6'd32);

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;

      rd_acc = bus.rd_en & ~empty;
      wr_acc = bus.wr_en & (~full | rd_acc);

      if (wr_acc) wr_ptr_d = wr_ptr_q + 5'd1;
      if (rd_acc) begin
         rd_ptr_d     = rd_ptr_q + 5'd1;
         dout_d       = mem_q[rd_ptr_q];
         dout_valid_d = 1'b1;
      end

      case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + 6'd1;
         2'b01:   count_d = count_q - 6'd1;
         default: count_d = count_q;
      endcase

      // A new error in the same cycle as clr_err wins.
      overflow_d  = (overflow_q  & ~bus.clr_err) | (bus.wr_en & ~wr_acc);
      underflow_d = (underflow_q & ~bus.clr_err) | (bus.rd_en & ~rd_acc);
   end

   // NOTE: the storage array has no reset; the pointers alone define what is
   // valid, and a reset port would stop it mapping onto distributed RAM.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= bus.din;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values, including the RAM read on full R+W.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.almost_full = (count_q >= 6'(AFULL_LVL));
   assign bus.count       = count_q;
   assign bus.dout        = dout_q;
   assign bus.dout_valid  = dout_valid_q;
   assign bus.overflow    = overflow_q;
   assign bus.underflow   = underflow_q;
endmodule
